// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two valid/ready requesters.
// Optional multi-cycle multiply hold (op 3'b101) enabled by defining ALU_ARB_MUL_MULTICYCLE_EN.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_data1_i,
  input  logic [31:0] req0_data2_i,
  input  logic [2:0]  req0_ctrl_i,
  output logic        resp0_valid_o,
  input  logic        resp0_ready_i,
  output logic [31:0] resp0_data_o,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_data1_i,
  input  logic [31:0] req1_data2_i,
  input  logic [2:0]  req1_ctrl_i,
  output logic        resp1_valid_o,
  input  logic        resp1_ready_i,
  output logic [31:0] resp1_data_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
  localparam logic [1:0] MWAIT = 2'd2;
  localparam logic [2:0] CTRL_MUL = 3'b101;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
`endif
  localparam logic [1:0] RESP  = 2'd3;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_mul_cycles_range
    $error("alu_arbiter: MUL_CYCLES must be in 1..15");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] result_q, result_d;
  logic        grant0, grant1;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
  logic [3:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    ctrl_d       = ctrl_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    cnt_d        = cnt_q;
`endif

    // Gated by rst_i so the ready outputs read 0 while reset is held.
    grant0 = rst_i && (state_q == IDLE) && req0_valid_i && (!req1_valid_i || last_grant_q);
    grant1 = rst_i && (state_q == IDLE) && req1_valid_i && (!req0_valid_i || !last_grant_q);

    case (state_q)
      IDLE: begin
        if (grant0) begin
          op1_d        = req0_data1_i;
          op2_d        = req0_data2_i;
          ctrl_d       = req0_ctrl_i;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (grant1) begin
          op1_d        = req1_data1_i;
          op2_d        = req1_data2_i;
          ctrl_d       = req1_ctrl_i;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
        if (ctrl_q == CTRL_MUL && MUL_CYCLES > 1) begin
          cnt_d   = MUL_LOAD;
          state_d = MWAIT;
        end else begin
          result_d = alu_data_i;
          state_d  = RESP;
        end
`else
        result_d = alu_data_i;
        state_d  = RESP;
`endif
      end
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
      // EXEC is the first execute cycle, so MWAIT spans MUL_CYCLES-1 cycles.
      MWAIT: begin
        if (cnt_q == 4'd1) begin
          result_d = alu_data_i;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      RESP: begin
        if (owner_q ? resp1_ready_i : resp0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      ctrl_q       <= ctrl_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req0_ready_o  = grant0;
  assign req1_ready_o  = grant1;
  assign resp0_valid_o = (state_q == RESP) && !owner_q;
  assign resp1_valid_o = (state_q == RESP) && owner_q;
  assign resp0_data_o  = result_q;
  assign resp1_data_o  = result_q;
  assign alu_data1_o   = op1_q;
  assign alu_data2_o   = op2_q;
  assign alu_ctrl_o    = ctrl_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, directed cases, random traffic.
module tb_alu_arbiter;
  localparam int unsigned MUL = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_data1_i = '0, req0_data2_i = '0, req1_data1_i = '0, req1_data2_i = '0;
  logic [2:0]  req0_ctrl_i = '0, req1_ctrl_i = '0;
  logic        resp0_valid_o, resp1_valid_o;
  logic        resp0_ready_i = 1'b0, resp1_ready_i = 1'b0;
  logic [31:0] resp0_data_o, resp1_data_o;
  logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
  logic [2:0]  alu_ctrl_o;

  alu_arbiter #(.MUL_CYCLES(MUL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .resp0_data_o(resp0_data_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .resp1_data_o(resp1_data_o),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_data_i(alu_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference ALU: 001 AND, 010 OR, 011 ADD, 100 SUB, 101 MUL, others 0.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'b001:  return a & b;
      3'b010:  return a | b;
      3'b011:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_f(input logic [2:0] c);
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    if (c == 3'b101) return 1 + int'(MUL);
`endif
    return 2;
  endfunction

  assign alu_data_i = alu_f(alu_data1_o, alu_data2_o, alu_ctrl_o);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Transaction-level model: one outstanding op, response window starts at accept cycle + latency.
  logic        m_busy = 1'b0, m_owner = 1'b0, m_last = 1'b1;
  logic [31:0] m_op1 = '0, m_op2 = '0, m_data = '0, m_res = '0;
  logic [2:0]  m_ctrl = '0;
  int          m_resp_cyc = 0;

  always @(negedge clk_i) begin
    logic er0, er1, in_resp;
    if (!rst_i) begin
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      m_op1 = '0; m_op2 = '0; m_ctrl = '0; m_data = '0; m_res = '0;
    end
    er0 = rst_i && !m_busy && req0_valid_i && (!req1_valid_i || m_last);
    er1 = rst_i && !m_busy && req1_valid_i && (!req0_valid_i || !m_last);
    in_resp = m_busy && (cyc >= m_resp_cyc);
    if (in_resp) m_res = m_data;
    check("m_req0_ready", 32'(req0_ready_o), 32'(er0));
    check("m_req1_ready", 32'(req1_ready_o), 32'(er1));
    check("m_resp0_valid", 32'(resp0_valid_o), 32'(in_resp && !m_owner));
    check("m_resp1_valid", 32'(resp1_valid_o), 32'(in_resp && m_owner));
    check("m_resp0_data", resp0_data_o, m_res);
    check("m_resp1_data", resp1_data_o, m_res);
    check("m_alu_data1", alu_data1_o, m_op1);
    check("m_alu_data2", alu_data2_o, m_op2);
    check("m_alu_ctrl", 32'(alu_ctrl_o), 32'(m_ctrl));
    if (rst_i) begin
      if (er0 || er1) begin
        m_busy  = 1'b1;
        m_owner = er1;
        m_last  = er1;
        m_op1   = er1 ? req1_data1_i : req0_data1_i;
        m_op2   = er1 ? req1_data2_i : req0_data2_i;
        m_ctrl  = er1 ? req1_ctrl_i  : req0_ctrl_i;
        m_data  = alu_f(m_op1, m_op2, m_ctrl);
        m_resp_cyc = cyc + lat_f(m_ctrl);
      end else if (in_resp && (m_owner ? resp1_ready_i : resp0_ready_i)) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants[$];
    int lat;
    repeat (3) step();
    check("rst_outputs", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, alu_ctrl_o},
          32'd0);
    rst_i = 1'b1;
    step();

    // Single add
    req0_valid_i = 1'b1; req0_data1_i = 32'd7; req0_data2_i = 32'd5; req0_ctrl_i = 3'b011;
    #1 check("add_ready", 32'(req0_ready_o), 32'd1);
    step(); req0_valid_i = 1'b0;
    #1 check("add_exec_novalid", 32'(resp0_valid_o), 32'd0);
    step();
    check("add_valid", 32'(resp0_valid_o), 32'd1);
    check("add_data", resp0_data_o, 32'd12);
    check("add_resp1_low", 32'(resp1_valid_o), 32'd0);
    resp0_ready_i = 1'b1;
    step(); resp0_ready_i = 1'b0;

    // Tie round-robin: last grant was 0, so sequence is 1,0,1,0
    req0_valid_i = 1'b1; req0_data1_i = 32'd9; req0_data2_i = 32'd4; req0_ctrl_i = 3'b100;
    req1_valid_i = 1'b1; req1_data1_i = 32'd3; req1_data2_i = 32'd5; req1_ctrl_i = 3'b100;
    resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      #1;
      check("tie_onehot", 32'(req0_ready_o && req1_ready_o), 32'd0);
      if (req0_ready_o) grants.push_back(0);
      if (req1_ready_o) grants.push_back(1);
      if (resp0_valid_o) check("tie_res0", resp0_data_o, 32'd5);
      if (resp1_valid_o) check("tie_res1", resp1_data_o, 32'hFFFF_FFFE);
      step();
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    check("tie_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < grants.size(); i++)
      check("tie_order", 32'(grants[i]), 32'(((i % 2) == 0) ? 1 : 0));
    repeat (3) step();
    resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;

    // Backpressure: last grant 0, so req1 alone is taken, then req0 waits
    req1_valid_i = 1'b1; req1_data1_i = 32'hF0F0_F0F0; req1_data2_i = 32'hFF00_FF00; req1_ctrl_i = 3'b001;
    #1 check("bp_accept", 32'(req1_ready_o), 32'd1);
    step();
    req1_valid_i = 1'b0;
    req0_valid_i = 1'b1; req0_data1_i = 32'd2; req0_data2_i = 32'd3; req0_ctrl_i = 3'b011;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(resp1_valid_o), 32'd1);
      check("bp_data", resp1_data_o, 32'hF000_F000);
      check("bp_req0_blocked", 32'(req0_ready_o), 32'd0);
      step();
    end
    resp1_ready_i = 1'b1;
    #1 check("bp_take_cycle_blocked", 32'(req0_ready_o), 32'd0);
    step(); resp1_ready_i = 1'b0;
    check("bp_next_accept", 32'(req0_ready_o), 32'd1);
    step(); req0_valid_i = 1'b0;
    resp0_ready_i = 1'b1; repeat (2) step(); resp0_ready_i = 1'b0;
    step();

    // Invalid ctrl
    req0_valid_i = 1'b1; req0_data1_i = 32'd1; req0_data2_i = 32'd1; req0_ctrl_i = 3'b111;
    step(); req0_valid_i = 1'b0;
    step();
    check("inv_valid", 32'(resp0_valid_o), 32'd1);
    check("inv_data", resp0_data_o, 32'd0);
    resp0_ready_i = 1'b1; step(); resp0_ready_i = 1'b0;

    // Multiply
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
    lat = 1 + int'(MUL);
`else
    lat = 2;
`endif
    req0_valid_i = 1'b1; req0_data1_i = 32'd6; req0_data2_i = 32'd7; req0_ctrl_i = 3'b101;
    step(); req0_valid_i = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check("mul_hold_op1", alu_data1_o, 32'd6);
      check("mul_hold_ctrl", 32'(alu_ctrl_o), 32'd5);
      check("mul_not_yet", 32'(resp0_valid_o), 32'd0);
      step();
    end
    check("mul_valid", 32'(resp0_valid_o), 32'd1);
    check("mul_data", resp0_data_o, 32'd42);
    resp0_ready_i = 1'b1; step(); resp0_ready_i = 1'b0;

    // Reset mid-EXEC
    req0_valid_i = 1'b1; req0_data1_i = 32'd3; req0_data2_i = 32'd4; req0_ctrl_i = 3'b011;
    step();
    rst_i = 1'b0;
    #1;
    check("rst_mid_ctl", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o, alu_ctrl_o}, 32'd0);
    check("rst_mid_data", alu_data1_o | alu_data2_o | resp0_data_o | resp1_data_o, 32'd0);
    step(); rst_i = 1'b1;
    #1 check("rst_release_ready", 32'(req0_ready_o), 32'd1);
    step(); req0_valid_i = 1'b0;
    resp0_ready_i = 1'b1; repeat (2) step(); resp0_ready_i = 1'b0;

    // Random traffic, model checks every cycle
    for (int i = 0; i < 4000; i++) begin
      req0_valid_i  = ($urandom_range(0, 2) != 0);
      req1_valid_i  = ($urandom_range(0, 2) != 0);
      req0_data1_i  = $urandom; req0_data2_i = $urandom; req0_ctrl_i = 3'($urandom_range(0, 7));
      req1_data1_i  = $urandom; req1_data2_i = $urandom; req1_ctrl_i = 3'($urandom_range(0, 7));
      resp0_ready_i = ($urandom_range(0, 1) != 0);
      resp1_ready_i = ($urandom_range(0, 1) != 0);
      rst_i         = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_i = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
